// File: rtl/prism_cfg_sequencer.sv
// prism_cfg_sequencer
//   Queues (address, data) configuration words from the peripheral bus and,
//   on start, loads them into the prism controller through its debug port
//   while prism is held in debug reset. Each word can optionally be read
//   back and compared. After the queue drains, reset is released and the
//   prism FSM is enabled. Direct host writes always win the debug port.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/ready/addr/data  queue push handshake
//   start, verify_en, abort    sequence control
//   host_wr/addr/wdata         direct host access (passthrough when idle)
//   dbg_addr/wr/wdata/rdata    prism debug port
//   dbg_reset, fsm_enable      prism control
//   busy, done, error, err_addr status
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | prism free-running off, host passthrough
// RESET   | prism held in debug reset for two cycles
// WRITE   | pop queue head onto the debug port
// CHECK   | compare read-back of last written word
// RUN     | reset released, prism FSM enabled
// FAULT   | verify mismatch, prism held in reset

module prism_cfg_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic          start,
  input  logic          verify_en,
  input  logic          abort,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [AW-1:0] dbg_addr,
  output logic          dbg_wr,
  output logic [DW-1:0] dbg_wdata,
  input  logic [DW-1:0] dbg_rdata,
  output logic          dbg_reset,
  output logic          fsm_enable,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_WRITE, S_CHECK, S_RUN, S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic          rcnt_q, rcnt_d;
  logic          done_q;
  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] cap_addr_q;
  logic [DW-1:0] cap_data_q;
  logic          error_q;
  logic [AW-1:0] err_addr_q;

  logic q_empty, q_full, push, pop, check_ok;

  assign q_empty   = (count_q == '0);
  assign q_full    = (count_q == FULL_CNT);
  assign cmd_ready = !q_full;
  assign push      = cmd_valid && !q_full;
  assign pop       = (state_q == S_WRITE) && !host_wr && !q_empty;
  assign check_ok  = (dbg_rdata == cap_data_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rcnt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      done_q  <= (state_d == S_RUN) && (state_q != S_RUN);
    end
  end

  // next state; the reset-hold timer loads on entry and counts down to zero
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RESET;
        S_RESET: if (rcnt_q == 1'b0) state_d = S_WRITE;
        S_WRITE: begin
          if (!host_wr) begin
            if (!q_empty) state_d = verify_en ? S_CHECK : S_WRITE;
            else          state_d = S_RUN;
          end
        end
        S_CHECK: if (!host_wr) state_d = check_ok ? S_WRITE : S_FAULT;
        S_RUN:   if (start) state_d = S_RESET;
        S_FAULT: if (start) state_d = S_RESET;
        default: state_d = S_IDLE;
      endcase
    end

    rcnt_d = rcnt_q;
    if (state_d == S_RESET && state_q != S_RESET) rcnt_d = 1'b1;
    else if (state_q == S_RESET)                  rcnt_d = rcnt_q - 1'b1;
  end

  // outputs; the host owns the port whenever the sequencer is not driving it
  always_comb begin
    dbg_reset  = (state_q == S_RESET) || (state_q == S_WRITE) ||
                 (state_q == S_CHECK) || (state_q == S_FAULT);
    fsm_enable = (state_q == S_RUN);
    busy       = (state_q == S_RESET) || (state_q == S_WRITE) ||
                 (state_q == S_CHECK);
    dbg_addr   = host_addr;
    dbg_wdata  = host_wdata;
    dbg_wr     = host_wr;
    if (pop) begin
      dbg_addr  = q_addr[head_q];
      dbg_wdata = q_data[head_q];
      dbg_wr    = 1'b1;
    end else if (state_q == S_CHECK && !host_wr) begin
      dbg_addr  = cap_addr_q;
      dbg_wdata = cap_data_q;
      dbg_wr    = 1'b0;
    end
  end

  assign done     = done_q;
  assign error    = error_q;
  assign err_addr = err_addr_q;

  // queue pointers and occupancy; abort flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (abort) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail_q] <= cmd_addr;
      q_data[tail_q] <= cmd_data;
    end
  end

  // captured word and sticky error; abort leaves error untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr_q <= '0;
      cap_data_q <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (pop) begin
        cap_addr_q <= q_addr[head_q];
        cap_data_q <= q_data[head_q];
      end
      if (!abort) begin
        if (state_q == S_IDLE && start) begin
          error_q    <= 1'b0;
          err_addr_q <= '0;
        end else if (state_q == S_CHECK && !host_wr && !check_ok) begin
          error_q    <= 1'b1;
          err_addr_q <= cap_addr_q;
        end
      end
    end
  end

endmodule
